// File: rtl/draw_pkg.sv
// Shared definitions for the bursted draw engine.
//   CMD_*          command codes carried on cmd_id
//   state_t        engine state encoding (idle, brush stamp, canvas clear)
//   step_coord     one-pixel cursor step with wrap or clamp at the canvas edge
//   sat_coord      saturate an absolute coordinate to the last pixel
package draw_pkg;

    localparam logic [3:0] CMD_NOP        = 4'd0;
    localparam logic [3:0] CMD_UP         = 4'd1;
    localparam logic [3:0] CMD_DOWN       = 4'd2;
    localparam logic [3:0] CMD_LEFT       = 4'd3;
    localparam logic [3:0] CMD_RIGHT      = 4'd4;
    localparam logic [3:0] CMD_SET_XY     = 4'd5;
    localparam logic [3:0] CMD_TOGGLE     = 4'd6;
    localparam logic [3:0] CMD_COLOR_NEXT = 4'd7;
    localparam logic [3:0] CMD_COLOR_PREV = 4'd8;
    localparam logic [3:0] CMD_PAINT      = 4'd9;
    localparam logic [3:0] CMD_BRUSH_INC  = 4'd10;
    localparam logic [3:0] CMD_BRUSH_DEC  = 4'd11;
    localparam logic [3:0] CMD_CLEAR      = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STAMP = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    // inc=1 steps up, inc=0 steps down; max_v is the last valid coordinate.
    function automatic int unsigned step_coord(input int unsigned v, input logic inc,
                                               input int unsigned max_v, input logic wrap);
        if (inc) begin
            if (v >= max_v) return wrap ? 32'd0 : max_v;
            return v + 32'd1;
        end
        if (v == 32'd0) return wrap ? max_v : 32'd0;
        return v - 32'd1;
    endfunction

    function automatic int unsigned sat_coord(input int unsigned v, input int unsigned max_v);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/draw_engine_bursted_if.sv
// Command and pixel-write bundle of the draw engine.
//   cmd_valid/cmd_id/x_in/y_in   command from the keyboard decoder
//   cmd_ready/cmd_drop           engine idle / busy-drop pulse
//   wr_valid/wr_x/wr_y/wr_color  pixel write toward the framebuffer
//   wr_ready                     framebuffer acceptance
// master: the engine side. slave: the decoder/framebuffer side.
interface draw_engine_bursted_if #(
    parameter int XW      = 6,
    parameter int YW      = 6,
    parameter int COLOR_W = 8
);
    logic               cmd_valid;
    logic [3:0]         cmd_id;
    logic [XW-1:0]      x_in;
    logic [YW-1:0]      y_in;
    logic               cmd_ready;
    logic               cmd_drop;
    logic               wr_valid;
    logic [XW-1:0]      wr_x;
    logic [YW-1:0]      wr_y;
    logic [COLOR_W-1:0] wr_color;
    logic               wr_ready;

    modport master (
        input  cmd_valid, cmd_id, x_in, y_in, wr_ready,
        output cmd_ready, cmd_drop, wr_valid, wr_x, wr_y, wr_color
    );

    modport slave (
        output cmd_valid, cmd_id, x_in, y_in, wr_ready,
        input  cmd_ready, cmd_drop, wr_valid, wr_x, wr_y, wr_color
    );
endinterface

// File: rtl/raster_gen.sv
// Row-major raster walker over a rectangle of extent_w x extent_h pixels
// anchored at (origin_x, origin_y). Used for brush stamps and canvas clears.
//   start       load origin/extent, present the first pixel next cycle
//   adv         move to the next pixel; on the last pixel the walk ends
//   x, y        current pixel (registered)
//   in_bounds   walk active and current pixel inside the canvas (registered)
//   last        current pixel is the final one of the rectangle (registered)
module raster_gen #(
    parameter int XW       = 6,
    parameter int YW       = 6,
    parameter int CANVAS_W = 64,
    parameter int CANVAS_H = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [XW-1:0] origin_x,
    input  logic [YW-1:0] origin_y,
    input  logic [XW:0]   extent_w,
    input  logic [YW:0]   extent_h,
    input  logic          adv,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          in_bounds,
    output logic          last
);
    localparam int XE = XW + 1;
    localparam int YE = YW + 1;
    localparam logic [XW:0] ONE_X = XE'(1);
    localparam logic [YW:0] ONE_Y = YE'(1);
    localparam logic [XW:0] W_LIM = XE'(CANVAS_W);
    localparam logic [YW:0] H_LIM = YE'(CANVAS_H);

    // One extra bit on the coordinates lets pixels past the canvas edge be
    // represented, so they can be recognised and skipped rather than wrapped.
    logic        run, nxt_run;
    logic [XW:0] cur_x, org_x, lim_x, off_x;
    logic [XW:0] nxt_cur_x, nxt_org_x, nxt_lim_x, nxt_off_x;
    logic [YW:0] cur_y, lim_y, off_y;
    logic [YW:0] nxt_cur_y, nxt_lim_y, nxt_off_y;

    always_comb begin
        nxt_run   = run;
        nxt_cur_x = cur_x;
        nxt_org_x = org_x;
        nxt_lim_x = lim_x;
        nxt_off_x = off_x;
        nxt_cur_y = cur_y;
        nxt_lim_y = lim_y;
        nxt_off_y = off_y;
        if (start) begin
            nxt_run   = 1'b1;
            nxt_cur_x = {1'b0, origin_x};
            nxt_org_x = {1'b0, origin_x};
            nxt_lim_x = extent_w - ONE_X;
            nxt_off_x = '0;
            nxt_cur_y = {1'b0, origin_y};
            nxt_lim_y = extent_h - ONE_Y;
            nxt_off_y = '0;
        end else if (adv && run) begin
            if (last) begin
                nxt_run = 1'b0;
            end else if (off_x == lim_x) begin
                nxt_off_x = '0;
                nxt_cur_x = org_x;
                nxt_off_y = off_y + ONE_Y;
                nxt_cur_y = cur_y + ONE_Y;
            end else begin
                nxt_off_x = off_x + ONE_X;
                nxt_cur_x = cur_x + ONE_X;
            end
        end
    end

    // Flags are computed from the next position so every output is a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            run       <= 1'b0;
            in_bounds <= 1'b0;
            last      <= 1'b0;
        end else begin
            run       <= nxt_run;
            in_bounds <= nxt_run && (nxt_cur_x < W_LIM) && (nxt_cur_y < H_LIM);
            last      <= nxt_run && (nxt_off_x == nxt_lim_x) && (nxt_off_y == nxt_lim_y);
        end
    end

    always_ff @(posedge clk) begin
        cur_x <= nxt_cur_x;
        org_x <= nxt_org_x;
        lim_x <= nxt_lim_x;
        off_x <= nxt_off_x;
        cur_y <= nxt_cur_y;
        lim_y <= nxt_lim_y;
        off_y <= nxt_off_y;
    end

    assign x = cur_x[XW-1:0];
    assign y = cur_y[YW-1:0];

endmodule

// File: rtl/draw_engine_bursted.sv
// Keyboard-driven draw engine with burst pixel writes.
// Decodes cursor, mode, colour and brush commands; a paint (or a move in
// draw mode) emits an NxN brush stamp at the cursor, CLEAR writes colour 0
// over the whole canvas. Both bursts go out on a ready/valid write port.
//   clk, reset         clock, synchronous active-high reset
//   bus                command + pixel-write bundle (master side)
//   mode               0 = move, 1 = draw
//   cursor_x/y         cursor position; tile_x/y = cursor / TILE
//   brush              brush side, 1..BRUSH_MAX
//   color_sel          selected colour index, 0..NUM_COLORS-1
module draw_engine_bursted
    import draw_pkg::*;
#(
    parameter  int CANVAS_W   = 64,
    parameter  int CANVAS_H   = 64,
    parameter  int TILE       = 16,
    parameter  int COLOR_W    = 8,
    parameter  int NUM_COLORS = 8,
    parameter  int BRUSH_MAX  = 4,
    parameter  int WRAP       = 1,
    localparam int XW         = $clog2(CANVAS_W),
    localparam int YW         = $clog2(CANVAS_H),
    localparam int BW         = $clog2(BRUSH_MAX + 1)
) (
    input  logic               clk,
    input  logic               reset,
    draw_engine_bursted_if.master bus,
    output logic               mode,
    output logic [XW-1:0]      cursor_x,
    output logic [YW-1:0]      cursor_y,
    output logic [XW-1:0]      tile_x,
    output logic [YW-1:0]      tile_y,
    output logic [BW-1:0]      brush,
    output logic [COLOR_W-1:0] color_sel
);
    localparam int XE = XW + 1;
    localparam int YE = YW + 1;

    state_t               state;
    logic                 ready_r, drop_r;
    logic                 accept, step;
    logic                 go_stamp, go_clear;
    logic [XW-1:0]        nx;
    logic [YW-1:0]        ny;
    logic                 n_mode;
    logic [BW-1:0]        n_brush;
    logic [COLOR_W-1:0]   n_color;
    logic [COLOR_W-1:0]   wr_color_r;
    logic [XW-1:0]        rg_x;
    logic [YW-1:0]        rg_y;
    logic                 rg_in_bounds, rg_last;
    logic [XW-1:0]        rg_org_x;
    logic [YW-1:0]        rg_org_y;
    logic [XW:0]          rg_ext_w;
    logic [YW:0]          rg_ext_h;

    assign accept = bus.cmd_valid && ready_r;
    // A clipped pixel has wr_valid=0 and is stepped over without waiting.
    assign step   = (state != ST_IDLE) && (!rg_in_bounds || bus.wr_ready);

    always_comb begin
        nx       = cursor_x;
        ny       = cursor_y;
        n_mode   = mode;
        n_brush  = brush;
        n_color  = color_sel;
        go_stamp = 1'b0;
        go_clear = 1'b0;
        if (accept) begin
            case (bus.cmd_id)
                CMD_UP: begin
                    ny = YW'(step_coord(32'(cursor_y), 1'b0, CANVAS_H - 1, WRAP != 0));
                    go_stamp = mode;
                end
                CMD_DOWN: begin
                    ny = YW'(step_coord(32'(cursor_y), 1'b1, CANVAS_H - 1, WRAP != 0));
                    go_stamp = mode;
                end
                CMD_LEFT: begin
                    nx = XW'(step_coord(32'(cursor_x), 1'b0, CANVAS_W - 1, WRAP != 0));
                    go_stamp = mode;
                end
                CMD_RIGHT: begin
                    nx = XW'(step_coord(32'(cursor_x), 1'b1, CANVAS_W - 1, WRAP != 0));
                    go_stamp = mode;
                end
                CMD_SET_XY: begin
                    nx = XW'(sat_coord(32'(bus.x_in), CANVAS_W - 1));
                    ny = YW'(sat_coord(32'(bus.y_in), CANVAS_H - 1));
                    go_stamp = mode;
                end
                CMD_TOGGLE: n_mode = !mode;
                CMD_COLOR_NEXT:
                    n_color = (color_sel >= COLOR_W'(NUM_COLORS - 1)) ? '0
                                                                     : color_sel + COLOR_W'(1);
                CMD_COLOR_PREV:
                    n_color = (color_sel == '0) ? COLOR_W'(NUM_COLORS - 1)
                                                : color_sel - COLOR_W'(1);
                CMD_PAINT: go_stamp = 1'b1;
                CMD_BRUSH_INC:
                    if (brush < BW'(BRUSH_MAX)) n_brush = brush + BW'(1);
                CMD_BRUSH_DEC:
                    if (brush > BW'(1)) n_brush = brush - BW'(1);
                CMD_CLEAR: go_clear = 1'b1;
                default: ;
            endcase
        end
    end

    // Stamps use the post-move cursor; clears walk the whole canvas.
    always_comb begin
        rg_org_x = go_clear ? '0 : nx;
        rg_org_y = go_clear ? '0 : ny;
        rg_ext_w = go_clear ? XE'(CANVAS_W) : XE'(brush);
        rg_ext_h = go_clear ? YE'(CANVAS_H) : YE'(brush);
    end

    raster_gen #(
        .XW       (XW),
        .YW       (YW),
        .CANVAS_W (CANVAS_W),
        .CANVAS_H (CANVAS_H)
    ) u_raster (
        .clk       (clk),
        .reset     (reset),
        .start     (go_stamp || go_clear),
        .origin_x  (rg_org_x),
        .origin_y  (rg_org_y),
        .extent_w  (rg_ext_w),
        .extent_h  (rg_ext_h),
        .adv       (step),
        .x         (rg_x),
        .y         (rg_y),
        .in_bounds (rg_in_bounds),
        .last      (rg_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ready_r   <= 1'b1;
            drop_r    <= 1'b0;
            mode      <= 1'b0;
            cursor_x  <= '0;
            cursor_y  <= '0;
            tile_x    <= '0;
            tile_y    <= '0;
            brush     <= BW'(1);
            color_sel <= COLOR_W'(1);
        end else begin
            drop_r    <= bus.cmd_valid && !ready_r;
            mode      <= n_mode;
            cursor_x  <= nx;
            cursor_y  <= ny;
            tile_x    <= XW'(32'(nx) / TILE);
            tile_y    <= YW'(32'(ny) / TILE);
            brush     <= n_brush;
            color_sel <= n_color;
            case (state)
                ST_IDLE: begin
                    if (go_stamp) begin
                        state   <= ST_STAMP;
                        ready_r <= 1'b0;
                    end else if (go_clear) begin
                        state   <= ST_CLEAR;
                        ready_r <= 1'b0;
                    end
                end
                ST_STAMP, ST_CLEAR: begin
                    if (step && rg_last) begin
                        state   <= ST_IDLE;
                        ready_r <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    // Burst colour is latched at entry so colour commands cannot disturb it.
    always_ff @(posedge clk) begin
        if (go_stamp)      wr_color_r <= color_sel;
        else if (go_clear) wr_color_r <= '0;
    end

    assign bus.cmd_ready = ready_r;
    assign bus.cmd_drop  = drop_r;
    assign bus.wr_valid  = rg_in_bounds;
    assign bus.wr_x      = rg_x;
    assign bus.wr_y      = rg_y;
    assign bus.wr_color  = wr_color_r;

endmodule
